// File: rtl/tvp5147_init_sequencer.sv
// tvp5147_init_sequencer: walks a constant register table and issues one
// single-byte I2C write per entry to the TVP5147M1 decoder, with per-entry
// retries, a per-phase handshake timeout and done/error reporting.
// Optional readback verification of every write: define VERIFY_READBACK_EN.
module tvp5147_init_sequencer #(
   parameter int unsigned NUM_REGS       = 8,
   parameter logic [7:0]  SLAVE_ADDR     = 8'hB8,
   parameter int unsigned POWERUP_CYCLES = 1024,
   parameter int unsigned RETRY_MAX      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_req,
   output logic             i2c_start,
   output logic             i2c_rw,
   output logic [7:0]       i2c_slave_addr,
   output logic [7:0]       i2c_sub_addr,
   output logic [7:0]       i2c_wdata,
   input  logic [7:0]       i2c_rdata,
   input  logic             i2c_busy,
   input  logic             i2c_ack_error,
   output logic             init_busy,
   output logic             init_done,
   output logic             init_error,
   output logic [IDX_W-1:0] fail_index
);

   localparam int unsigned RTY_W   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam int unsigned TMR_MAX = (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   // Register table: {sub_addr, data}; entries past the defaults read as zero
   function automatic logic [15:0] rom_entry(input int unsigned i);
      case (i)
         32'd0:   rom_entry = 16'h0200;
         32'd1:   rom_entry = 16'h036F;
         32'd2:   rom_entry = 16'h0400;
         32'd3:   rom_entry = 16'h0500;
         32'd4:   rom_entry = 16'h0F02;
         32'd5:   rom_entry = 16'h1B00;
         32'd6:   rom_entry = 16'h3340;
         32'd7:   rom_entry = 16'h3411;
         default: rom_entry = 16'h0000;
      endcase
   endfunction

   localparam logic [15:0] ROM0 = rom_entry(32'd0);

   typedef enum logic [3:0] {
      S_IDLE, S_PWR_WAIT, S_LOAD, S_REQ, S_WAIT,
      S_CHECK, S_RETRY, S_NEXT, S_DONE, S_FAIL, S_RB_CHECK
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [RTY_W-1:0]   rty_q, rty_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               rb_q, rb_d;
   logic [7:0]         sub_d, wdata_d;
   logic               rw_d, start_d, init_busy_d, init_done_d, init_error_d;
   logic [IDX_W-1:0]   fail_d;
   logic [15:0]        rom_c;
   logic               tmr_pwr_c, tmr_to_c, last_c, rty_left_c;

   assign rom_c      = rom_entry(32'(idx_q));
   assign tmr_pwr_c  = (tmr_q == TMR_W'(POWERUP_CYCLES - 1));
   assign tmr_to_c   = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
   assign last_c     = (idx_q == IDX_W'(NUM_REGS - 1));
   assign rty_left_c = (rty_q < RTY_W'(RETRY_MAX));

`ifndef VERIFY_READBACK_EN
   logic unused_rdata_c;
   assign unused_rdata_c = ^i2c_rdata;
`endif

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         rty_q          <= '0;
         tmr_q          <= '0;
         rb_q           <= 1'b0;
         i2c_start      <= 1'b0;
         i2c_rw         <= 1'b0;
         i2c_slave_addr <= SLAVE_ADDR;
         i2c_sub_addr   <= ROM0[15:8];
         i2c_wdata      <= ROM0[7:0];
         init_busy      <= 1'b0;
         init_done      <= 1'b0;
         init_error     <= 1'b0;
         fail_index     <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         rty_q          <= rty_d;
         tmr_q          <= tmr_d;
         rb_q           <= rb_d;
         i2c_start      <= start_d;
         i2c_rw         <= rw_d;
         i2c_slave_addr <= SLAVE_ADDR;
         i2c_sub_addr   <= sub_d;
         i2c_wdata      <= wdata_d;
         init_busy      <= init_busy_d;
         init_done      <= init_done_d;
         init_error     <= init_error_d;
         fail_index     <= fail_d;
      end
   end

   // Next-state: handshake with the controller, retry and table walk
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: if (init_req) state_d = S_PWR_WAIT;
         S_PWR_WAIT:             if (tmr_pwr_c) state_d = S_LOAD;
         S_LOAD:                 state_d = S_REQ;
         // start is held until the controller shows busy on its divided clock
         S_REQ: begin
            if (i2c_busy)      state_d = S_WAIT;
            else if (tmr_to_c) state_d = S_RETRY;
         end
         S_WAIT: begin
`ifdef VERIFY_READBACK_EN
            if (!i2c_busy)     state_d = rb_q ? S_RB_CHECK : S_CHECK;
`else
            if (!i2c_busy)     state_d = S_CHECK;
`endif
            else if (tmr_to_c) state_d = S_RETRY;
         end
         S_CHECK: begin
`ifdef VERIFY_READBACK_EN
            state_d = i2c_ack_error ? S_RETRY : S_LOAD;
`else
            state_d = i2c_ack_error ? S_RETRY : S_NEXT;
`endif
         end
`ifdef VERIFY_READBACK_EN
         S_RB_CHECK: state_d = (!i2c_ack_error && (i2c_rdata == i2c_wdata)) ? S_NEXT : S_RETRY;
`endif
         S_RETRY: state_d = rty_left_c ? S_LOAD : S_FAIL;
         S_NEXT:  state_d = last_c ? S_DONE : S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      idx_d        = idx_q;
      rty_d        = rty_q;
      rb_d         = rb_q;
      fail_d       = fail_index;
      sub_d        = i2c_sub_addr;
      wdata_d      = i2c_wdata;
      rw_d         = i2c_rw;
      tmr_d        = '0;
      start_d      = (state_d == S_REQ);
      init_busy_d  = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_FAIL);
      init_done_d  = (state_d == S_DONE);
      init_error_d = (state_d == S_FAIL);
      // timer restarts on every state change, counts while waiting
      if (state_d == state_q &&
          (state_q == S_PWR_WAIT || state_q == S_REQ || state_q == S_WAIT))
         tmr_d = tmr_q + TMR_W'(1);
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (init_req) begin
               idx_d  = '0;
               rty_d  = '0;
               rb_d   = 1'b0;
               fail_d = '0;
            end
         end
         S_LOAD: begin
            sub_d   = rom_c[15:8];
            wdata_d = rom_c[7:0];
            rw_d    = rb_q;
         end
`ifdef VERIFY_READBACK_EN
         S_CHECK: if (!i2c_ack_error) rb_d = 1'b1;
`endif
         S_RETRY: begin
            rb_d = 1'b0;
            if (rty_left_c) rty_d  = rty_q + RTY_W'(1);
            else            fail_d = idx_q;
         end
         S_NEXT: begin
            rb_d = 1'b0;
            if (!last_c) begin
               idx_d = idx_q + IDX_W'(1);
               rty_d = '0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/tvp5147_init_sequencer.md
Name: tvp5147_init_sequencer

Overview:
- Upstream command source for the I2C master controller that configures the TVP5147M1 video decoder.
- On request, waits a power-up settle time, then walks an internal register table of {sub_addr, data} pairs.
- Issues one single-byte I2C write per entry and checks each transfer for ACK.
- Retries failed writes, then reports done, or an error with the index of the failing entry.

Parameters:
- NUM_REGS, 8: number of table entries; table index width = clog2(NUM_REGS), minimum 1.
- SLAVE_ADDR, 8'hB8: 8-bit write-form device address; bit0 = 0, the controller ORs in R/W.
- POWERUP_CYCLES, 1024: clk cycles to wait after init_req before the first transfer.
- RETRY_MAX, 3: retries per entry after the first failed attempt.
- TIMEOUT_CYCLES, 65536: max clk cycles per handshake phase before the attempt counts as failed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- init_req  in  1  starts the sequence; sampled only in IDLE, DONE or FAIL
- i2c_start  out  1  transaction request to the controller
- i2c_rw  out  1  0 = write, 1 = read
- i2c_slave_addr  out  8  always SLAVE_ADDR
- i2c_sub_addr  out  8  register sub-address of the current entry
- i2c_wdata  out  8  write data of the current entry
- i2c_rdata  in  8  controller read data; used only when VERIFY_READBACK_EN is defined
- i2c_busy  in  1  controller busy
- i2c_ack_error  in  1  controller ACK error flag, sticky on the controller side
- init_busy  out  1  high from init_req acceptance until DONE or FAIL
- init_done  out  1  level, high in DONE
- init_error  out  1  level, high in FAIL
- fail_index  out  clog2(NUM_REGS)  index of the entry that exhausted its retries

Behaviour:
- Reset values:
  - All outputs 0, except i2c_slave_addr = SLAVE_ADDR and sub_addr/wdata = entry 0.
  - State IDLE; index, retry count and timers all 0.
- Table: constant case-ROM indexed by idx, held in a localparam-style case statement.
  - Default entries: (0x02,0x00), (0x03,0x6F), (0x04,0x00), (0x05,0x00), (0x0F,0x02), (0x1B,0x00), (0x33,0x40), (0x34,0x11).
  - Entries beyond 8 read as (0x00,0x00).
- FSM, one transition per clk:
  - IDLE/DONE/FAIL: on init_req=1 -> PWR_WAIT. Clear idx, retry count, timer, done, error, fail_index. init_busy=1.
  - PWR_WAIT: count to POWERUP_CYCLES-1 -> LOAD.
  - LOAD: drive sub_addr/wdata from ROM[idx], i2c_rw=0, clear timer -> REQ.
  - REQ: i2c_start=1, held until i2c_busy=1 observed -> WAIT (start drops the same edge). Reason: the controller samples start on its divided clock, so start stays high until acknowledged.
  - WAIT: on i2c_busy=0 -> CHECK.
  - CHECK: i2c_ack_error=0 -> NEXT; else -> RETRY.
  - RETRY: if retry count < RETRY_MAX, increment it -> LOAD. Else fail_index=idx -> FAIL.
  - NEXT: if idx = NUM_REGS-1 -> DONE; else idx+1, retry count=0 -> LOAD.
  - DONE: init_done=1, init_busy=0. FAIL: init_error=1, init_busy=0.
- Timeout:
  - Timer counts in REQ and WAIT and is cleared on entry to each.
  - Reaching TIMEOUT_CYCLES-1 -> RETRY and drops i2c_start.
- Boundaries:
  - init_req while init_busy=1: ignored.
  - i2c_busy already high on entry to REQ: treated as the acknowledge, REQ -> WAIT immediately.
  - Sticky ack_error: once set, every later attempt fails. The sequence ends in FAIL at that index; no attempt is made to mask it.
  - rst mid-sequence: immediate return to reset values and i2c_start=0. Abandoning a transfer in flight is accepted.
  - NUM_REGS=1: a single entry, then DONE.

Optional Feature:
- Macro: VERIFY_READBACK_EN.
- Defined:
  - CHECK success on a write goes to a readback: LOAD with i2c_rw=1, then REQ and WAIT.
  - Then RB_CHECK compares i2c_rdata with wdata.
  - Match -> NEXT. Mismatch or ack_error -> RETRY; the retry repeats the write.
- Undefined: i2c_rdata is unused, and every transfer is a write.

Test Plan:
- Nominal run, POWERUP_CYCLES=16, controller model ACKs all: init_req -> 8 start handshakes with sub_addr 0x02,0x03,0x04,0x05,0x0F,0x1B,0x33,0x34 in order; init_done=1, init_error=0, init_busy=0.
- Power-up wait: init_req at cycle T -> first i2c_start rises at T+1+16+1 (±1 documented), not earlier.
- NACK on entry 2 with ack_error held: exactly 1+RETRY_MAX=4 attempts on sub_addr 0x04, then init_error=1, fail_index=2, no start for 0x05.
- Controller never asserts busy: i2c_start held TIMEOUT_CYCLES, then dropped; after 4 attempts FAIL with fail_index=0.
- Reset while WAIT on entry 5: rst pulse -> i2c_start=0, done/error=0, IDLE. A new init_req restarts from sub_addr 0x02.
- VERIFY_READBACK_EN, model returns 0x6E for 0x03: the write+read pair for 0x03 repeats 4 times -> FAIL, fail_index=1.
